// File: rtl/demux_frame_serializer.sv
// Serializes channel/data words LSB-first onto the demux data line while holding
// the select lines steady for the whole frame; one word can wait in a pending slot.
module demux_frame_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [1:0]       i_in_chan,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_s0,
  output logic             o_s1,
  output logic             o_f,
  output logic             o_frame_last,
  output logic             o_busy
);

  localparam int MAXC = ((WIDTH - 1) > (GAP - 1)) ? (WIDTH - 1) : (GAP - 1);
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] WLAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GLAST = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_s0;
  logic             r_s1;
  logic [1:0]       r_pend_chan;
  logic [WIDTH-1:0] r_pend_data;
  logic             r_pend_valid;

  logic w_last;
  logic w_gap_end;
  logic w_load;
  logic w_accept;

  assign w_last    = (r_state == SHIFT) && (r_cnt == WLAST);
  assign w_gap_end = (r_state == GAPW) && (r_cnt == GLAST);
  // The engine pulls the pending word when idle, at the end of the gap, or
  // straight off the final bit when no gap is configured.
  assign w_load    = r_pend_valid &&
                     ((r_state == IDLE) || (w_last && (GAP == 0)) || w_gap_end);
  assign w_accept  = i_in_valid && !r_pend_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_sh         <= '0;
      r_cnt        <= '0;
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_pend_chan  <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pend_chan  <= i_in_chan;
        r_pend_data  <= i_in_data;
        r_pend_valid <= 1'b1;
      end else if (w_load) begin
        r_pend_valid <= 1'b0;
      end

      if (w_load) begin
        r_sh    <= r_pend_data;
        r_s1    <= r_pend_chan[1];
        r_s0    <= r_pend_chan[0];
        r_cnt   <= '0;
        r_state <= SHIFT;
      end else begin
        case (r_state)
          SHIFT: begin
            r_sh <= r_sh >> 1;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= (GAP > 0) ? GAPW : IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          GAPW: begin
            if (w_gap_end) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_in_ready   = ~r_pend_valid;
  assign o_s0         = r_s0;
  assign o_s1         = r_s1;
  assign o_f          = (r_state == SHIFT) & r_sh[0];
  assign o_frame_last = w_last;
  assign o_busy       = (r_state != IDLE) | r_pend_valid;

endmodule

// File: tb/tb_demux_frame_serializer.sv
// Directed bench: a per-cycle vector table for the default configuration plus
// hand-written sequences for mid-frame reset and the gapless variant.
module tb_demux_frame_serializer;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [1:0] chan;
    logic [7:0] data;
    logic       f;
    logic       s1;
    logic       s0;
    logic       last;
    logic       busy;
    logic       ready;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       aValid, aReady, aS0, aS1, aF, aLast, aBusy;
  logic [1:0] aChan;
  logic [7:0] aData;
  logic       bValid, bReady, bS0, bS1, bF, bLast, bBusy;
  logic [1:0] bChan;
  logic [7:0] bData;

  int   nChecks = 0;
  int   nFails  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  demux_frame_serializer #(.WIDTH(8), .GAP(1)) uGap1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(aValid), .o_in_ready(aReady),
    .i_in_chan(aChan), .i_in_data(aData), .o_s0(aS0), .o_s1(aS1),
    .o_f(aF), .o_frame_last(aLast), .o_busy(aBusy)
  );

  demux_frame_serializer #(.WIDTH(8), .GAP(0)) uGap0 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(bValid), .o_in_ready(bReady),
    .i_in_chan(bChan), .i_in_data(bData), .o_s0(bS0), .o_s1(bS1),
    .o_f(bF), .o_frame_last(bLast), .o_busy(bBusy)
  );

  task automatic addVec(input logic r, input logic v, input logic [1:0] c,
                        input logic [7:0] d, input logic f, input logic s1,
                        input logic s0, input logic last, input logic busy,
                        input logic ready);
    vec_t t;
    t.rst = r; t.valid = v; t.chan = c; t.data = d;
    t.f = f; t.s1 = s1; t.s0 = s0; t.last = last; t.busy = busy; t.ready = ready;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t t, input int idx);
    rst    = t.rst;
    aValid = t.valid;
    aChan  = t.chan;
    aData  = t.data;
    @(negedge clk);
    checkOutput("f",          idx, {7'd0, aF},     {7'd0, t.f});
    checkOutput("s1s0",       idx, {6'd0, aS1, aS0}, {6'd0, t.s1, t.s0});
    checkOutput("frame_last", idx, {7'd0, aLast},  {7'd0, t.last});
    checkOutput("busy",       idx, {7'd0, aBusy},  {7'd0, t.busy});
    checkOutput("in_ready",   idx, {7'd0, aReady}, {7'd0, t.ready});
    tick();
  endtask

  initial begin
    logic [7:0] wA5;
    logic [7:0] wFF;
    logic [7:0] w81;
    logic [7:0] w0F;
    logic [7:0] gWords[3];
    logic [1:0] gChans[3];
    logic [7:0] cur;
    int         idx;
    int         rel;
    logic       readySeen;

    wA5 = 8'hA5; wFF = 8'hFF; w81 = 8'h81; w0F = 8'h0F;
    gWords[0] = 8'h5A; gWords[1] = 8'hC3; gWords[2] = 8'h0F;
    gChans[0] = 2'd1;  gChans[1] = 2'd2;  gChans[2] = 2'd3;

    // Reset held with a word offered: nothing may be accepted.
    addVec(1, 1, 2'd3, 8'hFF, 0, 0, 0, 0, 0, 1);
    addVec(1, 1, 2'd3, 8'hFF, 0, 0, 0, 0, 0, 1);
    addVec(0, 0, 2'd0, 8'h00, 0, 0, 0, 0, 0, 1);
    // Single frame, channel 2, A5.
    addVec(0, 1, 2'd2, 8'hA5, 0, 0, 0, 0, 0, 1);
    addVec(0, 0, 2'd0, 8'h00, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      addVec(0, 0, 2'd0, 8'h00, wA5[i], 1, 0, (i == 7), 1, 1);
    addVec(0, 0, 2'd0, 8'h00, 0, 1, 0, 0, 1, 1);
    addVec(0, 0, 2'd0, 8'h00, 0, 1, 0, 0, 0, 1);
    // Back-to-back with backpressure: FF on chan 0, then 81 on chan 3.
    addVec(0, 1, 2'd0, 8'hFF, 0, 1, 0, 0, 0, 1);
    addVec(0, 1, 2'd2, 8'h11, 0, 1, 0, 0, 1, 0);
    addVec(0, 1, 2'd3, 8'h81, wFF[0], 0, 0, 0, 1, 1);
    for (int i = 1; i < 8; i++)
      addVec(0, 1, 2'd1, 8'(i * 37), wFF[i], 0, 0, (i == 7), 1, 0);
    addVec(0, 0, 2'd0, 8'h00, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      addVec(0, 0, 2'd0, 8'h00, w81[i], 1, 1, (i == 7), 1, 1);
    addVec(0, 0, 2'd0, 8'h00, 0, 1, 1, 0, 1, 1);
    addVec(0, 0, 2'd0, 8'h00, 0, 1, 1, 0, 0, 1);

    rst = 1'b1;
    aValid = 1'b0; aChan = 2'd0; aData = 8'h00;
    bValid = 1'b0; bChan = 2'd0; bData = 8'h00;
    tick();

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Reset during bit 4 while a second word is pending.
    rst = 1'b0; aValid = 1'b1; aChan = 2'd1; aData = w0F;
    @(negedge clk);
    checkOutput("rm_ready0", 0, {7'd0, aReady}, 8'd1);
    tick();
    aValid = 1'b0;
    tick();
    aValid = 1'b1; aChan = 2'd2; aData = 8'hAA;
    @(negedge clk);
    checkOutput("rm_bit0", 0, {7'd0, aF}, {7'd0, w0F[0]});
    checkOutput("rm_sel", 0, {6'd0, aS1, aS0}, 8'd1);
    tick();
    aValid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rm_bitn", i, {7'd0, aF}, {7'd0, w0F[i]});
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rm_pend", 4, {6'd0, aBusy, aReady}, 8'd2);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("rm_after", i, {5'd0, aF, aBusy, aReady}, 8'd1);
      if (i == 0) checkOutput("rm_sel0", i, {6'd0, aS1, aS0}, 8'd0);
      tick();
    end

    // Gapless instance: three words stream as 24 contiguous bits.
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bValid = (idx < 3);
      bChan  = gChans[(idx < 3) ? idx : 2];
      bData  = gWords[(idx < 3) ? idx : 2];
      @(negedge clk);
      readySeen = bReady;
      if (cyc >= 2 && cyc <= 25) begin
        rel = cyc - 2;
        cur = gWords[rel / 8];
        checkOutput("g0_f", cyc, {7'd0, bF}, {7'd0, cur[rel % 8]});
        checkOutput("g0_last", cyc, {7'd0, bLast}, {7'd0, ((rel % 8) == 7)});
        checkOutput("g0_sel", cyc, {6'd0, bS1, bS0}, {6'd0, gChans[rel / 8]});
      end
      if (cyc == 26)
        checkOutput("g0_idle", cyc, {6'd0, bF, bBusy}, 8'd0);
      @(posedge clk);
      if (bValid && readySeen) idx++;
      #1;
    end
    checkOutput("g0_accepts", 0, 8'(idx), 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
